// File: rtl/regfile_sb.sv
// Parametrised two-read/one-write register file with post-reset clear sequencer,
// optional write-to-read bypass and a per-register pending-write scoreboard.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [ADDR_W-1:0] A_Address,
  input  logic [ADDR_W-1:0] B_Address,
  output logic [DATA_W-1:0] A_Data,
  output logic [DATA_W-1:0] B_Data,
  output logic              A_Busy,
  output logic              B_Busy,
  input  logic [ADDR_W-1:0] C_Address,
  input  logic [DATA_W-1:0] C_Data,
  input  logic              Write,
  input  logic              Issue,
  input  logic [ADDR_W-1:0] Issue_Address,
  output logic              Ready
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   ptr, ptr_nxt;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic                wr_en, is_en, ready;

  function automatic logic addr_valid(input logic [ADDR_W-1:0] addr);
    return (int'(addr) < NUM_REGS) && !((ZERO_REG != 0) && (addr == '0));
  endfunction

  // Returns {busy, data} as seen by one read port.
  function automatic logic [DATA_W:0] read_port(input logic [ADDR_W-1:0] addr);
    if (!ready || !addr_valid(addr))
      return '0;
    else if ((BYPASS != 0) && wr_en && (C_Address == addr))
      return {1'b0, C_Data};
    else
      return {busy[addr], regs[addr]};
  endfunction

  assign ready = (state == RUN);
  assign Ready = ready;
  assign wr_en = ready && Write && addr_valid(C_Address);
  assign is_en = ready && Issue && addr_valid(Issue_Address);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      CLEAR: begin
        if (ptr == LAST) state_nxt = RUN;
        else             ptr_nxt   = ptr + 1'b1;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Array has no reset; the CLEAR sweep zeroes it one entry per edge.
  always_ff @(posedge Clk) begin
    if (state == CLEAR)
      regs[ptr] <= '0;
    else if (wr_en)
      regs[C_Address] <= C_Data;
  end

  // Issue is applied after write so a same-address issue supersedes the clear.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      busy <= '0;
    end else begin
      if (wr_en) busy[C_Address]     <= 1'b0;
      if (is_en) busy[Issue_Address] <= 1'b1;
    end
  end

  always_comb begin
    {A_Busy, A_Data} = read_port(A_Address);
    {B_Busy, B_Data} = read_port(B_Address);
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: three instances (default, no-bypass,
// 20 registers) share stimulus; expectations are queued and checked in order.
module tb_regfile_sb;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [4:0]  A_Address, B_Address, C_Address, Issue_Address;
  logic [31:0] C_Data;
  logic        Write, Issue;

  logic [31:0] a_data [3];
  logic [31:0] b_data [3];
  logic        a_busy [3];
  logic        b_busy [3];
  logic        ready  [3];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  regfile_sb u_def (
    .Clk(Clk), .Reset_n(Reset_n), .A_Address(A_Address), .B_Address(B_Address),
    .A_Data(a_data[0]), .B_Data(b_data[0]), .A_Busy(a_busy[0]), .B_Busy(b_busy[0]),
    .C_Address(C_Address), .C_Data(C_Data), .Write(Write), .Issue(Issue),
    .Issue_Address(Issue_Address), .Ready(ready[0]));

  regfile_sb #(.BYPASS(0)) u_nb (
    .Clk(Clk), .Reset_n(Reset_n), .A_Address(A_Address), .B_Address(B_Address),
    .A_Data(a_data[1]), .B_Data(b_data[1]), .A_Busy(a_busy[1]), .B_Busy(b_busy[1]),
    .C_Address(C_Address), .C_Data(C_Data), .Write(Write), .Issue(Issue),
    .Issue_Address(Issue_Address), .Ready(ready[1]));

  regfile_sb #(.NUM_REGS(20)) u_20 (
    .Clk(Clk), .Reset_n(Reset_n), .A_Address(A_Address), .B_Address(B_Address),
    .A_Data(a_data[2]), .B_Data(b_data[2]), .A_Busy(a_busy[2]), .B_Busy(b_busy[2]),
    .C_Address(C_Address), .C_Data(C_Data), .Write(Write), .Issue(Issue),
    .Issue_Address(Issue_Address), .Ready(ready[2]));

  localparam int AD = 0, AB = 1, BD = 2, BB = 3, RD = 4;

  typedef struct {
    string       name;
    int          inst;
    int          port;
    logic [31:0] val;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [4:0]  a;
    logic [4:0]  b;
    logic [31:0] ad;
    logic        ab;
    logic [31:0] bd;
    logic        bb;
  } vec_t;
  vec_t tbl [4];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  function automatic logic [31:0] actual(input int inst, input int port);
    case (port)
      AD:      return a_data[inst];
      AB:      return {31'b0, a_busy[inst]};
      BD:      return b_data[inst];
      BB:      return {31'b0, b_busy[inst]};
      default: return {31'b0, ready[inst]};
    endcase
  endfunction

  task automatic expect_out(input string nm, input int inst, input int port,
                            input logic [31:0] v);
    exp_t e;
    e.name = $sformatf("%s[i%0d p%0d]", nm, inst, port);
    e.inst = inst;
    e.port = port;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic expect_all(input string nm, input int port, input logic [31:0] v);
    for (int i = 0; i < 3; i++) expect_out(nm, i, port, v);
  endtask

  task automatic drain();
    exp_t e;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp(e.name, actual(e.inst, e.port), e.val);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    Write = 1'b0;
    Issue = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int exp_def, input int exp_20);
    int edges [3];
    for (int i = 0; i < 3; i++) edges[i] = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge Clk);
      #1;
      for (int i = 0; i < 3; i++)
        if (ready[i] && edges[i] < 0) edges[i] = n;
      if (ready[0] && ready[1] && ready[2]) break;
    end
    cmp({tag, " ready edges def"}, edges[0], exp_def);
    cmp({tag, " ready edges nb"},  edges[1], exp_def);
    cmp({tag, " ready edges r20"}, edges[2], exp_20);
  endtask

  initial begin
    tbl[0] = '{a: 5'd3,  b: 5'd7,  ad: 32'h12345678, ab: 1'b0, bd: 32'h55, bb: 1'b0};
    tbl[1] = '{a: 5'd9,  b: 5'd4,  ad: 32'h99,       ab: 1'b1, bd: 32'h0,  bb: 1'b1};
    tbl[2] = '{a: 5'd6,  b: 5'd0,  ad: 32'h66,       ab: 1'b0, bd: 32'h0,  bb: 1'b0};
    tbl[3] = '{a: 5'd31, b: 5'd10, ad: 32'h0,        ab: 1'b0, bd: 32'h0,  bb: 1'b0};

    // Reset with writes attempted throughout the clear sweep
    Reset_n = 1'b0;
    Issue = 1'b0; Issue_Address = '0;
    Write = 1'b1; C_Address = 5'd5; C_Data = 32'hDEADBEEF;
    A_Address = 5'd5; B_Address = 5'd5;
    repeat (3) @(posedge Clk);
    #1;
    expect_all("rst ready", RD, 32'h0);
    expect_all("rst a_data", AD, 32'h0);
    expect_all("rst a_busy", AB, 32'h0);
    drain();
    @(negedge Clk);
    Reset_n = 1'b1;
    wait_ready("t1", 32, 20);
    idle();
    expect_out("t1 reg5", 0, AD, 32'h0);
    expect_out("t1 reg5", 1, AD, 32'h0);
    expect_out("t1 reg5", 2, AD, 32'hDEADBEEF);
    drain();

    // Write with bypass / without bypass, zero register
    tick();
    Write = 1'b1; C_Address = 5'd3; C_Data = 32'h12345678; A_Address = 5'd3;
    expect_out("t2 same cyc", 0, AD, 32'h12345678);
    expect_out("t2 same cyc", 1, AD, 32'h0);
    expect_out("t2 same cyc", 2, AD, 32'h12345678);
    drain();
    tick(); idle();
    expect_all("t2 next cyc", AD, 32'h12345678);
    drain();
    Write = 1'b1; C_Address = 5'd0; C_Data = 32'hFFFFFFFF; A_Address = 5'd0;
    expect_all("t2 zero same", AD, 32'h0);
    drain();
    tick(); idle();
    expect_all("t2 zero next", AD, 32'h0);
    drain();

    // Scoreboard set then clear
    Issue = 1'b1; Issue_Address = 5'd7;
    tick(); idle();
    A_Address = 5'd7;
    expect_all("t3 busy", AB, 32'h1);
    drain();
    Write = 1'b1; C_Address = 5'd7; C_Data = 32'h55;
    expect_out("t3 wr busy", 0, AB, 32'h0);
    expect_out("t3 wr data", 0, AD, 32'h55);
    expect_out("t3 wr busy", 1, AB, 32'h1);
    expect_out("t3 wr data", 1, AD, 32'h0);
    expect_out("t3 wr busy", 2, AB, 32'h0);
    drain();
    tick(); idle();
    expect_all("t3 after busy", AB, 32'h0);
    expect_all("t3 after data", AD, 32'h55);
    drain();

    // Simultaneous issue and write
    A_Address = 5'd0;
    Issue = 1'b1; Issue_Address = 5'd9; Write = 1'b1; C_Address = 5'd9; C_Data = 32'h99;
    tick(); idle();
    A_Address = 5'd9;
    expect_all("t4 same busy", AB, 32'h1);
    expect_all("t4 same data", AD, 32'h99);
    drain();
    Issue = 1'b1; Issue_Address = 5'd4; Write = 1'b1; C_Address = 5'd6; C_Data = 32'h66;
    tick(); idle();
    A_Address = 5'd4; B_Address = 5'd6;
    expect_all("t4 busy4", AB, 32'h1);
    expect_all("t4 busy6", BB, 32'h0);
    expect_all("t4 data6", BD, 32'h66);
    drain();

    // Table of steady-state reads
    for (int k = 0; k < 4; k++) begin
      A_Address = tbl[k].a;
      B_Address = tbl[k].b;
      expect_all($sformatf("tbl%0d a_data", k), AD, tbl[k].ad);
      expect_all($sformatf("tbl%0d a_busy", k), AB, {31'b0, tbl[k].ab});
      expect_all($sformatf("tbl%0d b_data", k), BD, tbl[k].bd);
      expect_all($sformatf("tbl%0d b_busy", k), BB, {31'b0, tbl[k].bb});
      drain();
      tick();
    end

    // Out-of-range address on the 20-register instance
    Write = 1'b1; C_Address = 5'd25; C_Data = 32'h1;
    Issue = 1'b1; Issue_Address = 5'd25; A_Address = 5'd25;
    expect_out("t6 same data", 2, AD, 32'h0);
    expect_out("t6 same busy", 2, AB, 32'h0);
    expect_out("t6 bypass", 0, AD, 32'h1);
    drain();
    tick(); idle();
    expect_out("t6 r20 data", 2, AD, 32'h0);
    expect_out("t6 r20 busy", 2, AB, 32'h0);
    expect_out("t6 def data", 0, AD, 32'h1);
    expect_out("t6 def busy", 0, AB, 32'h1);
    expect_out("t6 nb busy",  1, AB, 32'h1);
    drain();

    // Reset pulse in the middle of a cycle
    Write = 1'b1; C_Address = 5'd2; C_Data = 32'hA5A5A5A5;
    tick(); idle();
    Issue = 1'b1; Issue_Address = 5'd2;
    tick(); idle();
    A_Address = 5'd2; B_Address = 5'd2;
    expect_all("t5 pre data", BD, 32'hA5A5A5A5);
    expect_all("t5 pre busy", BB, 32'h1);
    drain();
    #1 Reset_n = 1'b0;
    expect_all("t5 rst ready", RD, 32'h0);
    expect_all("t5 rst a_data", AD, 32'h0);
    expect_all("t5 rst b_busy", BB, 32'h0);
    expect_all("t5 rst b_data", BD, 32'h0);
    drain();
    #1 Reset_n = 1'b1;
    wait_ready("t5", 32, 20);
    expect_all("t5 post data", BD, 32'h0);
    expect_all("t5 post busy", BB, 32'h0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the 32x32 two-read/one-write register file.
- Adds a clocked write port, an asynchronous active-low reset, and a post-reset clear sequencer that zeroes the array.
- Adds optional write-to-read bypass and a per-register pending-write scoreboard, so the pipeline control can detect RAW hazards.
- Sits between decode (read/issue) and writeback (write) in the datapath.

Parameters:
- DATA_W, 32: register width in bits.
- ADDR_W, 5: address width.
- NUM_REGS, 32: number of implemented registers; must satisfy 2 <= NUM_REGS <= 2**ADDR_W.
- ZERO_REG, 1: when 1, register 0 reads 0 and ignores writes and issues.
- BYPASS, 1: when 1, a same-cycle write is forwarded to the read ports and suppresses busy.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- A_Address  input  ADDR_W  read port A address.
- B_Address  input  ADDR_W  read port B address.
- A_Data  output  DATA_W  read port A data (combinational).
- B_Data  output  DATA_W  read port B data (combinational).
- A_Busy  output  1  register at A_Address has a pending write.
- B_Busy  output  1  register at B_Address has a pending write.
- C_Address  input  ADDR_W  write address.
- C_Data  input  DATA_W  write data.
- Write  input  1  write enable; the write also clears the scoreboard bit for C_Address.
- Issue  input  1  marks the register at Issue_Address as pending.
- Issue_Address  input  ADDR_W  destination being issued.
- Ready  output  1  high once clearing is complete; writes and issues are accepted only when high.

Behaviour:
- Clock and reset: single clock Clk; reset Reset_n is asynchronous and active-low.
- Reset assertion (async, also mid-operation):
  - state goes to CLEAR, clear pointer goes to 0, Ready goes to 0.
  - all scoreboard bits go to 0.
  - A_Data, B_Data, A_Busy and B_Busy are forced to 0 while Ready is 0.
- CLEAR state:
  - each rising edge after Reset_n deasserts writes 0 to reg[ptr] and increments ptr.
  - when ptr equals NUM_REGS-1, that edge writes the final register and moves to RUN.
  - Ready goes high after exactly NUM_REGS edges.
  - Write and Issue are ignored.
- RUN state: stays in RUN until reset.
- Valid address: an address is valid when it is below NUM_REGS and, if ZERO_REG is 1, not 0.
- Write (RUN only): on a rising edge with Write=1 and C_Address valid, reg[C_Address] takes C_Data. Writes to invalid addresses are dropped silently.
- Read (port A; port B identical):
  - A_Address >= NUM_REGS: A_Data=0, A_Busy=0.
  - A_Address=0 with ZERO_REG=1: A_Data=0, A_Busy=0.
  - BYPASS=1 with Write=1, C_Address valid and C_Address==A_Address: A_Data=C_Data, A_Busy=0.
  - otherwise: A_Data=reg[A_Address], A_Busy=busy[A_Address].
- Write-to-read latency: 0 cycles with bypass, 1 cycle without. With BYPASS=0, a read of the address being written returns the old value in that cycle.
- Scoreboard (RUN only, per rising edge):
  - Issue=1 with a valid Issue_Address sets busy[Issue_Address].
  - Write=1 with a valid C_Address clears busy[C_Address].
  - Issue and Write to the same address in the same cycle: set wins, because the new producer supersedes.
  - Issue and Write to different addresses in the same cycle: both take effect.
  - Issue to an already-busy register leaves it busy (no counting).
- Write without a prior Issue: allowed; the data is written and the busy bit stays 0.
- Width: data is stored unmodified (no truncation or extension); DATA_W is the full width on every path.

Test Plan:
1. Reset, then count edges: hold Reset_n=0 for 3 edges, release, drive Write=1 C_Address=5 C_Data=0xDEADBEEF every cycle.
   -> Ready rises after exactly 32 edges; reg5 reads 0x00000000, because writes during CLEAR are ignored.
2. Write, bypass, zero-register: in RUN, write reg3=0x12345678 with A_Address=3 in the same cycle.
   -> A_Data=0x12345678 in that cycle (BYPASS=1); with BYPASS=0, the same stimulus gives 0 in that cycle and 0x12345678 on the next.
   -> A write of 0xFFFFFFFF to reg0 leaves A_Address=0 reading 0.
3. Scoreboard set/clear: Issue reg7, then read A_Address=7.
   -> A_Busy=1 on the next cycle.
   -> Write reg7=0x55: A_Busy=0 in the same cycle (bypass) and A_Data=0x55; busy bit is 0 after the edge.
4. Simultaneous issue and write: Issue_Address=9 and C_Address=9 on one edge.
   -> busy[9]=1 afterwards and reg9 holds C_Data.
   -> Issue reg4 with Write reg6 on one edge: busy[4]=1, busy[6]=0.
5. Reset mid-operation: with reg2=0xA5A5A5A5 and busy[2]=1, pulse Reset_n low between clock edges.
   -> Ready=0 and busy=0 immediately, outputs forced to 0.
   -> After 32 edges, reg2 reads 0 and B_Busy=0.
6. Out-of-range addresses: NUM_REGS=20, ADDR_W=5; write reg25=0x1 and issue reg25.
   -> No state change; A_Address=25 gives A_Data=0 and A_Busy=0; Ready rises 20 edges after reset.
